// File: rtl/wb_grf_if.sv
// rtl/wb_grf_if.sv - MEM/WB write-back and decode read-port bundle for wb_grf
interface wb_grf_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       A3;
  logic [31:0]      AO;
  logic [31:0]      DR;
  logic [31:0]      PCp4;
  logic             RegWrite;
  logic             MemtoReg;
  logic [1:0]       Link;
  logic             AWAY;
  logic [4:0]       RA1;
  logic [4:0]       RA2;
  logic [31:0]      RD1;
  logic [31:0]      RD2;
  logic             WB_en;
  logic [4:0]       WB_addr;
  logic [31:0]      WB_data;
  logic [CNT_W-1:0] commit_cnt;

  modport master (
    output A3, AO, DR, PCp4, RegWrite, MemtoReg, Link, AWAY, RA1, RA2,
    input  RD1, RD2, WB_en, WB_addr, WB_data, commit_cnt
  );

  modport slave (
    input  A3, AO, DR, PCp4, RegWrite, MemtoReg, Link, AWAY, RA1, RA2,
    output RD1, RD2, WB_en, WB_addr, WB_data, commit_cnt
  );
endinterface

// File: rtl/wb_grf.sv
// rtl/wb_grf.sv - write-back select, 32x32 register file, commit counter
// Optional write-before-read bypass on the read ports: GRF_BYPASS_EN
module wb_grf #(
  parameter logic [31:0] GP_INIT = 32'h0000_1800,
  parameter logic [31:0] SP_INIT = 32'h0000_2FFC,
  parameter int          CNT_W   = 32
) (
  input logic        CLK,
  input logic        reset,
  wb_grf_if.slave    bus
);

  logic [31:0]      regs [0:31];
  logic [31:0]      wb_data;
  logic             wb_en;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rd1;
  logic [31:0]      rd2;

  always_comb begin
    wb_data = bus.AO;
    unique case (bus.Link)
      2'b00: wb_data = bus.MemtoReg ? bus.DR : bus.AO;
      2'b01: wb_data = bus.PCp4 + 32'd4;
      2'b10: wb_data = bus.PCp4;
      2'b11: wb_data = bus.AO;
    endcase
  end

  // $0 writes and cancelled instructions never retire
  assign wb_en = bus.RegWrite & ~bus.AWAY & (bus.A3 != 5'd0);

  always_ff @(posedge CLK) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
      regs[28] <= GP_INIT;
      regs[29] <= SP_INIT;
      cnt_q    <= '0;
    end else if (wb_en) begin
      regs[bus.A3] <= wb_data;
      cnt_q        <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    rd1 = (bus.RA1 == 5'd0) ? 32'd0 : regs[bus.RA1];
    rd2 = (bus.RA2 == 5'd0) ? 32'd0 : regs[bus.RA2];
`ifdef GRF_BYPASS_EN
    if (wb_en && (bus.RA1 == bus.A3)) rd1 = wb_data;
    if (wb_en && (bus.RA2 == bus.A3)) rd2 = wb_data;
`endif
  end

  assign bus.RD1        = rd1;
  assign bus.RD2        = rd2;
  assign bus.WB_en      = wb_en;
  assign bus.WB_addr    = bus.A3;
  assign bus.WB_data    = wb_data;
  assign bus.commit_cnt = cnt_q;

endmodule

// File: tb/tb_wb_grf.sv
// tb/tb_wb_grf.sv - scoreboard bench for wb_grf (32-bit and 4-bit counter instances)
module tb_wb_grf;
`ifdef GRF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CLK;
  logic reset;

  wb_grf_if #(.CNT_W(32)) bus ();
  wb_grf_if #(.CNT_W(4))  bus4 ();

  wb_grf #(.CNT_W(32)) dut (.CLK(CLK), .reset(reset), .bus(bus));
  wb_grf #(.CNT_W(4))  dut4 (.CLK(CLK), .reset(reset), .bus(bus4));

  assign bus4.A3       = bus.A3;
  assign bus4.AO       = bus.AO;
  assign bus4.DR       = bus.DR;
  assign bus4.PCp4     = bus.PCp4;
  assign bus4.RegWrite = bus.RegWrite;
  assign bus4.MemtoReg = bus.MemtoReg;
  assign bus4.Link     = bus.Link;
  assign bus4.AWAY     = bus.AWAY;
  assign bus4.RA1      = bus.RA1;
  assign bus4.RA2      = bus.RA2;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference architectural state
  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;
  int          m_cnt4;
  bit          p_rst;
  bit          p_we;
  logic [4:0]  p_a3;
  logic [31:0] p_wd;

  function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit we,
                                         input logic [4:0] a3, input logic [31:0] wd);
    if (ra == 5'd0) return 32'd0;
    if (BYP && we && ra == a3) return wd;
    return m_regs[ra];
  endfunction

  task automatic drive(input bit rst, input logic [4:0] a3, input logic [31:0] ao,
                       input logic [31:0] dr, input logic [31:0] pc, input bit rw,
                       input bit m2r, input logic [1:0] lk, input bit aw,
                       input logic [4:0] r1, input logic [4:0] r2);
    exp_t        e;
    logic [31:0] wd;
    bit          we;
    @(posedge CLK);
    if (!p_rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_regs[28] = 32'h0000_1800;
      m_regs[29] = 32'h0000_2FFC;
      m_cnt  = 32'd0;
      m_cnt4 = 0;
    end else if (p_we) begin
      m_regs[p_a3] = p_wd;
      m_cnt  = m_cnt + 32'd1;
      m_cnt4 = (m_cnt4 + 1) % 16;
    end
    #1;
    reset        = rst;
    bus.A3       = a3;
    bus.AO       = ao;
    bus.DR       = dr;
    bus.PCp4     = pc;
    bus.RegWrite = rw;
    bus.MemtoReg = m2r;
    bus.Link     = lk;
    bus.AWAY     = aw;
    bus.RA1      = r1;
    bus.RA2      = r2;
    case (lk)
      2'd0:    wd = m2r ? dr : ao;
      2'd1:    wd = pc + 32'd4;
      2'd2:    wd = pc;
      default: wd = ao;
    endcase
    we     = rw && !aw && (a3 != 5'd0);
    e.rd1  = exp_rd(r1, we, a3, wd);
    e.rd2  = exp_rd(r2, we, a3, wd);
    e.we   = we;
    e.wa   = a3;
    e.wd   = wd;
    e.cnt  = m_cnt;
    e.cnt4 = 4'(m_cnt4);
    q.push_back(e);
    p_rst = rst;
    p_we  = we;
    p_a3  = a3;
    p_wd  = wd;
  endtask

  task automatic rd(input logic [4:0] r1, input logic [4:0] r2);
    drive(1'b1, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0, r1, r2);
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (vector %0d)", n, act, exp, vectors);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, compare against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() != 0) begin
        e = q.pop_front();
        vectors++;
        chk("RD1", bus.RD1, e.rd1);
        chk("RD2", bus.RD2, e.rd2);
        chk("WB_en", {31'd0, bus.WB_en}, {31'd0, e.we});
        chk("WB_addr", {27'd0, bus.WB_addr}, {27'd0, e.wa});
        chk("WB_data", bus.WB_data, e.wd);
        chk("commit_cnt", bus.commit_cnt, e.cnt);
        chk("commit_cnt4", {28'd0, bus4.commit_cnt}, {28'd0, e.cnt4});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int wait_cnt;
    reset = 1'b0;
    bus.A3 = '0; bus.AO = '0; bus.DR = '0; bus.PCp4 = '0;
    bus.RegWrite = 1'b0; bus.MemtoReg = 1'b0; bus.Link = '0; bus.AWAY = 1'b0;
    bus.RA1 = '0; bus.RA2 = '0;
    p_rst = 1'b0; p_we = 1'b0; p_a3 = '0; p_wd = '0;
    repeat (2) @(posedge CLK);

    // Reset values
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd28, 5'd29);
    rd(5'd28, 5'd29);
    rd(5'd5, 5'd0);

    // Source select into $8
    drive(1'b1, 5'd8, 32'h1234, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 5'd8, 5'd8);
    drive(1'b1, 5'd8, 32'h0, 32'hABCD, 32'h0, 1'b1, 1'b1, 2'b00, 1'b0, 5'd8, 5'd0);
    drive(1'b1, 5'd8, 32'h0, 32'h0, 32'h3004, 1'b1, 1'b0, 2'b01, 1'b0, 5'd8, 5'd0);
    drive(1'b1, 5'd8, 32'h0, 32'h0, 32'h3004, 1'b1, 1'b0, 2'b10, 1'b0, 5'd8, 5'd0);
    drive(1'b1, 5'd8, 32'h9999, 32'h0, 32'h0, 1'b1, 1'b0, 2'b11, 1'b0, 5'd8, 5'd0);
    rd(5'd8, 5'd8);

    // Suppression: $0 write and cancelled write
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0, 5'd9);
    drive(1'b1, 5'd9, 32'hDEAD, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1, 5'd9, 5'd0);
    rd(5'd9, 5'd0);

    // Same-cycle read of the register being written
    drive(1'b1, 5'd10, 32'h55AA, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 5'd10, 5'd10);
    rd(5'd10, 5'd10);

    // Reset collides with a write to $29
    drive(1'b0, 5'd29, 32'h77, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 5'd29, 5'd10);
    rd(5'd29, 5'd10);

    // 17 commits wrap the 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 5'(1 + (i % 31)), $urandom, $urandom, $urandom, 1'b1,
            1'($urandom), 2'($urandom), 1'b0, 5'($urandom), 5'($urandom));
    end
    rd(5'd1, 5'd17);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) != 0), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom),
            $urandom, $urandom, $urandom, 1'($urandom_range(0, 3) != 0),
            1'($urandom), 2'($urandom), ($urandom_range(0, 5) == 0),
            5'($urandom), 5'($urandom));
    end
    rd(5'd28, 5'd29);

    wait_cnt = 0;
    while (q.size() != 0 && wait_cnt < 10) begin
      @(posedge CLK);
      wait_cnt++;
    end
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_grf.md
Name: wb_grf

Overview:
- Write-back end of the MEM/WB pipeline register.
- Consumes the MEM/WB outputs, selects the write-back value and commits it into the 32x32 general register file.
- Provides the two decode-stage read ports.
- Exports the live write-back value and a committed-write counter, so the hazard/forward logic and the bench can observe architectural retirement.

Parameters:
- GP_INIT, 32'h0000_1800, reset value of $28.
- SP_INIT, 32'h0000_2FFC, reset value of $29.
- CNT_W, 32, width of commit counter.

Ports:
- CLK  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low (0 = reset).
- A3  in  5  destination register from MEM/WB.
- AO  in  32  ALU result from MEM/WB.
- DR  in  32  load data from MEM/WB.
- PCp4  in  32  PC+4 of the WB instruction.
- RegWrite  in  1  write request.
- MemtoReg  in  1  1 = write DR, 0 = write AO.
- Link  in  2  link select.
- AWAY  in  1  instruction cancelled by exception/interrupt.
- RA1  in  5  read address 1 (D stage).
- RA2  in  5  read address 2 (D stage).
- RD1  out  32  read data 1.
- RD2  out  32  read data 2.
- WB_en  out  1  effective write this cycle.
- WB_addr  out  5  effective write address.
- WB_data  out  32  selected write-back value.
- commit_cnt  out  CNT_W  number of committed register writes.

Behaviour:
- Write-data select (combinational):
  - Link==2'b00: MemtoReg ? DR : AO.
  - Link==2'b01: PCp4+4 (jal/jalr with delay slot).
  - Link==2'b10: PCp4.
  - Link==2'b11: AO.
  - All additions are 32-bit and wrap modulo 2^32.
- WB_en = RegWrite & ~AWAY & (A3 != 0). WB_addr = A3. WB_data = selected value. All three are combinational.
- Commit: on posedge CLK with reset==1 and WB_en==1, regs[A3] <= WB_data and commit_cnt <= commit_cnt+1. commit_cnt wraps from all-ones to 0.
- $0: never written and always reads 0, including when A3==0 with RegWrite==1. Such a write does not increment commit_cnt.
- AWAY==1: suppresses the write and the count regardless of RegWrite.
- Reads: RD1 = (RA1==0) ? 0 : regs[RA1], combinational. RD2 is identical using RA2.
- Reset: on posedge CLK with reset==0:
  - All registers become 0, except regs[28]=GP_INIT and regs[29]=SP_INIT.
  - commit_cnt becomes 0.
  - Any pending write in that cycle is dropped; reset wins over a simultaneous write.
  - RD1/RD2 reflect the reset values from the next cycle onward.
- Reset mid-stream: reset held low for N cycles means no commits during those N cycles. The first commit can occur on the first edge with reset==1.
- Latency: one cycle from WB inputs to stored value.
- Same-cycle read of the register being written: see Optional Feature.
- Both read ports may address the same register with identical results.

Optional Feature:
- Macro: GRF_BYPASS_EN.
- Defined: if WB_en==1 and RAx==A3, RDx returns WB_data in the same cycle (write-before-read). This removes the need for a W-to-D forward path in the hazard unit.
- Undefined: RDx returns the stored value, i.e. the old contents, until the next edge. The hazard unit must then forward from WB_addr/WB_data.
- Unaffected either way: storage, WB_* outputs and commit_cnt.

Test Plan:
- Reset:
  - Stimulus: hold reset=0 for 2 cycles, then read RA1=28, RA2=29, then RA1=5.
  - Required response: RD1=32'h1800, RD2=32'h2FFC, commit_cnt=0; RD1=0 for RA1=5.
- Source select:
  - Stimulus: A3=8 with RegWrite=1, in four cycles:
    - Link=00, MemtoReg=0, AO=32'h1234.
    - Link=00, MemtoReg=1, DR=32'hABCD.
    - Link=01, PCp4=32'h3004.
    - Link=10, PCp4=32'h3004.
  - Required response: reading RA1=8 after each cycle gives 32'h1234, 32'hABCD, 32'h3008, 32'h3004; commit_cnt=4.
- Suppression:
  - Stimulus: A3=0 with AO=32'hFFFF_FFFF and RegWrite=1; then A3=9 with AWAY=1.
  - Required response: RD for $0 is 0; $9 is unchanged; WB_en=0 both cycles; commit_cnt unchanged.
- Bypass:
  - Stimulus: WB_en to $10 with 32'h55AA, RA1=RA2=10, same cycle.
  - Required response: with GRF_BYPASS_EN, RD1=RD2=32'h55AA. Without it, the old value; 32'h55AA after the edge.
- Reset collision:
  - Stimulus: reset=0 in the same cycle as a write of 32'h77 to $29.
  - Required response: after the edge $29=32'h2FFC and commit_cnt=0.
- Counter wrap:
  - Stimulus: with CNT_W=4, perform 17 valid writes.
  - Required response: commit_cnt=1.
